// File: rtl/fas_pkg.sv
// Shared types for the FAS frame sequencer: processing FSM states, default
// frame length and the ping-pong bank index type.
package fas_pkg;

  localparam int FAS_FRAME_LEN = 16;

  typedef logic bank_t;

  typedef enum logic [2:0] {
    IDLE,
    FFT_START,
    FFT_WAIT,
    ANA_START,
    ANA_WAIT,
    DONE
  } fas_state_t;

endpackage

// File: rtl/fas_bank_tracker.sv
// Ping-pong bank bookkeeping: full flags, fill/read bank pointers and the
// keep-or-discard decision taken when a frame finishes filling.
module fas_bank_tracker
  import fas_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       wrap,
  input  logic       rel,
  output bank_t      wr_bank,
  output bank_t      rd_bank,
  output logic [1:0] full,
  output logic       overrun
);

  logic       keep;
  logic [1:0] full_d;

  // A bank released on this edge already counts as free for the wrap check,
  // so a frame finishing together with the analyst is never lost.
  always_comb begin
    keep   = ~full[wr_bank] | (rel & (rd_bank == wr_bank));
    full_d = full;
    if (rel)
      full_d[rd_bank] = 1'b0;
    if (wrap && keep)
      full_d[wr_bank] = 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      full    <= 2'b00;
      wr_bank <= 1'b0;
      rd_bank <= 1'b0;
      overrun <= 1'b0;
    end else begin
      full <= full_d;
      if (rel)
        rd_bank <= ~rd_bank;
      if (wrap) begin
        if (keep)
          wr_bank <= ~wr_bank;
        else
          overrun <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/fas_frame_ctrl.sv
// FAS frame sequencer: counts FIR samples into frames, steers them into the
// ping-pong buffer and runs FFT then analyst per frame. Optional watchdog
// is built when FAS_CTRL_TIMEOUT_EN is defined.
module fas_frame_ctrl
  import fas_pkg::*;
#(
  parameter  int FRAME_LEN   = FAS_FRAME_LEN,
  parameter  int NUM_FRAMES  = 8,
  parameter  int TIMEOUT_CYC = 255,
  localparam int AW          = $clog2(FRAME_LEN),
  localparam int CW          = $clog2(NUM_FRAMES + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          fir_valid,
  output logic          stp_wr_en,
  output logic [AW-1:0] stp_wr_addr,
  output logic          stp_wr_bank,
  output logic          fft_start,
  output logic          fft_bank,
  input  logic          fft_done,
  output logic          ana_start,
  input  logic          ana_done,
  output logic          done,
  output logic [CW-1:0] frame_cnt,
  output logic          all_done,
  output logic          overrun,
  output logic          timeout
);

  fas_state_t    state_q, state_d;
  logic [AW-1:0] sample_cnt;
  logic [1:0]    full;
  bank_t         wr_bank, rd_bank;
  logic          accept, wrap, finish, rel, abort;

  function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] v);
    return (v == CW'(NUM_FRAMES)) ? v : v + CW'(1);
  endfunction

  assign all_done    = (frame_cnt == CW'(NUM_FRAMES));
  assign accept      = fir_valid & ~all_done;
  assign wrap        = accept & (sample_cnt == AW'(FRAME_LEN - 1));
  assign finish      = (state_q == ANA_WAIT) & ana_done;
  assign rel         = finish | abort;
  assign stp_wr_en   = accept;
  assign stp_wr_addr = sample_cnt;
  assign stp_wr_bank = wr_bank;
  assign fft_bank    = rd_bank;

  fas_bank_tracker u_bank_tracker (
    .clk     (clk),
    .rst     (rst),
    .wrap    (wrap),
    .rel     (rel),
    .wr_bank (wr_bank),
    .rd_bank (rd_bank),
    .full    (full),
    .overrun (overrun)
  );

  // Any gap in fir_valid abandons the partial frame.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      sample_cnt <= '0;
    else if (!fir_valid)
      sample_cnt <= '0;
    else if (accept)
      sample_cnt <= sample_cnt + AW'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      frame_cnt <= '0;
    end else begin
      state_q <= state_d;
      if (finish)
        frame_cnt <= sat_inc(frame_cnt);
    end
  end

  always_comb begin
    state_d   = state_q;
    fft_start = 1'b0;
    ana_start = 1'b0;
    done      = 1'b0;
    case (state_q)
      IDLE:      if (full[rd_bank] && !all_done) state_d = FFT_START;
      FFT_START: begin
        fft_start = 1'b1;
        state_d   = FFT_WAIT;
      end
      FFT_WAIT: begin
        if (fft_done)   state_d = ANA_START;
        else if (abort) state_d = IDLE;
      end
      ANA_START: begin
        ana_start = 1'b1;
        state_d   = ANA_WAIT;
      end
      ANA_WAIT: begin
        if (ana_done)   state_d = DONE;
        else if (abort) state_d = IDLE;
      end
      DONE: begin
        done    = 1'b1;
        state_d = IDLE;
      end
      default:   state_d = IDLE;
    endcase
  end

`ifdef FAS_CTRL_TIMEOUT_EN
  localparam int WDW = $clog2(TIMEOUT_CYC + 1);

  logic [WDW-1:0] wd_cnt;
  logic           waiting;
  logic           timeout_q;

  // Fires on the TIMEOUT_CYC-th cycle spent in a wait state unless the
  // awaited completion arrives on that same cycle.
  assign waiting = (state_q == FFT_WAIT) | (state_q == ANA_WAIT);
  assign abort   = waiting & (wd_cnt == WDW'(TIMEOUT_CYC - 1)) &
                   ~((state_q == FFT_WAIT) ? fft_done : ana_done);
  assign timeout = timeout_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wd_cnt    <= '0;
      timeout_q <= 1'b0;
    end else begin
      if (waiting && (state_d == state_q))
        wd_cnt <= wd_cnt + WDW'(1);
      else
        wd_cnt <= '0;
      if (abort)
        timeout_q <= 1'b1;
    end
  end
`else
  // Keeps the watchdog limit referenced when no watchdog is built.
  logic [31:0] unused_timeout_cyc;
  assign unused_timeout_cyc = 32'(TIMEOUT_CYC);
  assign abort   = 1'b0;
  assign timeout = 1'b0;
`endif

endmodule

// File: tb/tb_fas_frame_ctrl.sv
// Self-checking bench for fas_frame_ctrl: directed scenarios plus randomized
// traffic, all compared every cycle against a frame-level reference model.
module tb_fas_frame_ctrl;

  localparam int FL = 16;
  localparam int NF = 2;
  localparam int TO = 20;
  localparam int CW = $clog2(NF + 1);

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          fir_valid = 1'b0;
  logic          fft_done = 1'b0;
  logic          ana_done = 1'b0;
  logic          stp_wr_en, stp_wr_bank, fft_start, fft_bank, ana_start;
  logic          done, all_done, overrun, timeout;
  logic [3:0]    stp_wr_addr;
  logic [CW-1:0] frame_cnt;

  always #5 clk = ~clk;

  fas_frame_ctrl #(
    .FRAME_LEN   (FL),
    .NUM_FRAMES  (NF),
    .TIMEOUT_CYC (TO)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .fir_valid   (fir_valid),
    .stp_wr_en   (stp_wr_en),
    .stp_wr_addr (stp_wr_addr),
    .stp_wr_bank (stp_wr_bank),
    .fft_start   (fft_start),
    .fft_bank    (fft_bank),
    .fft_done    (fft_done),
    .ana_start   (ana_start),
    .ana_done    (ana_done),
    .done        (done),
    .frame_cnt   (frame_cnt),
    .all_done    (all_done),
    .overrun     (overrun),
    .timeout     (timeout)
  );

  int vectors = 0;
  int miscompares = 0;

  // Reference model: phase of the frame under processing, banks holding
  // unprocessed frames, and the counters visible on the ports.
  localparam int PH_IDLE = 0, PH_FFT_GO = 1, PH_FFT = 2, PH_ANA_GO = 3, PH_ANA = 4, PH_FIN = 5;
  int  m_cnt, m_frames, m_phase, m_age;
  bit  m_wr, m_rd, m_over, m_to;
  bit  pend[$];

  // Responders: completion pulses after programmed latencies.
  int fft_lat, ana_lat, fft_cd, ana_cd, stray_pct;

  task automatic chk1(input string tag, input logic obs, input logic exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %b, expected %b", tag, obs, exp);
    end
  endtask

  task automatic chkn(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
    end
  endtask

  function automatic bit queued(input bit b);
    foreach (pend[i]) if (pend[i] == b) return 1'b1;
    return 1'b0;
  endfunction

  task automatic model_reset();
    m_cnt = 0; m_frames = 0; m_phase = PH_IDLE; m_age = 0;
    m_wr = 1'b0; m_rd = 1'b0; m_over = 1'b0; m_to = 1'b0;
    pend.delete();
  endtask

  task automatic model_update();
    bit alld, acc, wrap, waiting, wdone, to_hit, fin;
    int nphase;
    alld    = (m_frames == NF);
    acc     = fir_valid && !alld;
    wrap    = acc && (m_cnt == FL - 1);
    waiting = (m_phase == PH_FFT) || (m_phase == PH_ANA);
    wdone   = (m_phase == PH_FFT) ? fft_done : ana_done;
    to_hit  = 1'b0;
`ifdef FAS_CTRL_TIMEOUT_EN
    to_hit  = waiting && !wdone && (m_age + 1 == TO);
`endif
    fin     = (m_phase == PH_ANA) && ana_done;
    nphase  = m_phase;
    case (m_phase)
      PH_IDLE:   if (queued(m_rd) && !alld) nphase = PH_FFT_GO;
      PH_FFT_GO: nphase = PH_FFT;
      PH_FFT:    if (fft_done) nphase = PH_ANA_GO; else if (to_hit) nphase = PH_IDLE;
      PH_ANA_GO: nphase = PH_ANA;
      PH_ANA:    if (fin) nphase = PH_FIN; else if (to_hit) nphase = PH_IDLE;
      default:   nphase = PH_IDLE;
    endcase
    m_age = (waiting && nphase == m_phase) ? m_age + 1 : 0;
    if (to_hit) m_to = 1'b1;
    // Release first, so a bank freed on this edge is free for the wrap below.
    if (fin || to_hit) begin
      for (int i = pend.size() - 1; i >= 0; i--) if (pend[i] == m_rd) pend.delete(i);
      m_rd = ~m_rd;
    end
    if (fin && m_frames < NF) m_frames++;
    if (wrap) begin
      if (!queued(m_wr)) begin
        pend.push_back(m_wr);
        m_wr = ~m_wr;
      end else begin
        m_over = 1'b1;
      end
    end
    if (!fir_valid) m_cnt = 0;
    else if (acc) m_cnt = (m_cnt + 1) % FL;
    m_phase = nphase;
  endtask

  task automatic check_all();
    chk1("stp_wr_en", stp_wr_en, fir_valid && (m_frames != NF));
    chkn("stp_wr_addr", 32'(stp_wr_addr), m_cnt);
    chk1("stp_wr_bank", stp_wr_bank, m_wr);
    chk1("fft_start", fft_start, m_phase == PH_FFT_GO);
    chk1("fft_bank", fft_bank, m_rd);
    chk1("ana_start", ana_start, m_phase == PH_ANA_GO);
    chk1("done", done, m_phase == PH_FIN);
    chkn("frame_cnt", 32'(frame_cnt), m_frames);
    chk1("all_done", all_done, m_frames == NF);
    chk1("overrun", overrun, m_over);
    chk1("timeout", timeout, m_to);
  endtask

  // One clock: drive inputs at the falling edge, model the rising edge,
  // then compare at the next falling edge.
  task automatic step(input bit v);
    fir_valid = v;
    fft_done  = (fft_cd == 1) || (stray_pct > 0 && $urandom_range(0, 99) < stray_pct);
    ana_done  = (ana_cd == 1) || (stray_pct > 0 && $urandom_range(0, 99) < stray_pct);
    if (fft_cd > 0) fft_cd--;
    if (ana_cd > 0) ana_cd--;
    @(posedge clk);
    model_update();
    @(negedge clk);
    check_all();
    if (fft_start && fft_lat > 0) fft_cd = fft_lat;
    if (ana_start) ana_cd = ana_lat;
  endtask

  task automatic reset_dut();
    fir_valid = 1'b0; fft_done = 1'b0; ana_done = 1'b0;
    fft_cd = 0; ana_cd = 0; stray_pct = 0;
    rst = 1'b1;
    model_reset();
    #1;
    chk1("rst_fft_start", fft_start, 1'b0);
    chk1("rst_ana_start", ana_start, 1'b0);
    chk1("rst_done", done, 1'b0);
    chk1("rst_overrun", overrun, 1'b0);
    chk1("rst_all_done", all_done, 1'b0);
    chk1("rst_timeout", timeout, 1'b0);
    chkn("rst_frame_cnt", 32'(frame_cnt), 0);
    chkn("rst_wr_addr", 32'(stp_wr_addr), 0);
    chk1("rst_wr_bank", stp_wr_bank, 1'b0);
    chk1("rst_fft_bank", fft_bank, 1'b0);
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    int k_done, ndone, nst, vp;

    // Single frame: FFT 10 cycles, analyst 3 cycles.
    reset_dut();
    fft_lat = 10; ana_lat = 3;
    repeat (16) step(1'b1);
    chk1("s1_no_early_start", fft_start, 1'b0);
    step(1'b0);
    chk1("s1_fft_start", fft_start, 1'b1);
    chk1("s1_fft_bank", fft_bank, 1'b0);
    k_done = -1; ndone = 0; nst = 0;
    for (int k = 1; k <= 40; k++) begin
      step(1'b0);
      if (fft_start) nst++;
      if (done) begin
        ndone++;
        if (k_done < 0) k_done = k;
      end
    end
    chkn("s1_done_cycle", k_done, 13);
    chkn("s1_done_count", ndone, 1);
    chkn("s1_no_restart", nst, 0);
    chkn("s1_frame_cnt", 32'(frame_cnt), 1);
    chk1("s1_overrun", overrun, 1'b0);

    // Slow FFT: frame 3 lost, frame 4 refills bank 0.
    reset_dut();
    fft_lat = 40; ana_lat = 3;
    repeat (47) step(1'b1);
    chk1("s2_overrun_before", overrun, 1'b0);
    step(1'b1);
    chk1("s2_overrun", overrun, 1'b1);
    for (int i = 0; i < 15; i++) begin
      step(1'b1);
      chk1("s2_frame4_bank", stp_wr_bank, 1'b0);
    end
    repeat (120) step(1'b0);

    // Dropout after 9 samples, then a clean frame.
    reset_dut();
    fft_lat = 4; ana_lat = 2; nst = 0;
    repeat (9) begin
      step(1'b1);
      if (fft_start) nst++;
    end
    step(1'b0);
    for (int i = 0; i < 16; i++) begin
      chkn("s3_wr_addr", 32'(stp_wr_addr), i);
      chk1("s3_wr_bank", stp_wr_bank, 1'b0);
      step(1'b1);
      if (fft_start) nst++;
    end
    chkn("s3_no_partial_start", nst, 0);
    chk1("s3_overrun", overrun, 1'b0);
    step(1'b0);
    chk1("s3_fft_start", fft_start, 1'b1);
    repeat (20) step(1'b0);

    // Release and frame wrap on the same edge (both banks full).
    reset_dut();
    fft_lat = 28; ana_lat = 3;
    repeat (47) step(1'b1);
    chk1("s4_no_done_yet", done, 1'b0);
    step(1'b1);
    chk1("s4_done_at_wrap", done, 1'b1);
    chk1("s4_no_overrun", overrun, 1'b0);
    chk1("s4_wr_bank_toggled", stp_wr_bank, 1'b1);
    chk1("s4_rd_bank", fft_bank, 1'b1);
    chkn("s4_frame_cnt", 32'(frame_cnt), 1);
    repeat (60) step(1'b0);

    // Completion after NF frames; further samples refused.
    reset_dut();
    fft_lat = 5; ana_lat = 2;
    repeat (32) step(1'b1);
    for (int k = 0; k < 60 && !all_done; k++) step(1'b0);
    chk1("s5_all_done", all_done, 1'b1);
    chkn("s5_frame_cnt", 32'(frame_cnt), NF);
    nst = 0;
    repeat (20) begin
      step(1'b1);
      chk1("s5_wr_en_blocked", stp_wr_en, 1'b0);
      if (fft_start) nst++;
    end
    chkn("s5_no_more_starts", nst, 0);

    // Asynchronous reset in the middle of busy operation.
    reset_dut();
    fft_lat = 40; ana_lat = 3;
    repeat (50) step(1'b1);
    chk1("s6_overrun_pre", overrun, 1'b1);
    reset_dut();

`ifdef FAS_CTRL_TIMEOUT_EN
    // Watchdog: FFT never completes.
    reset_dut();
    fft_lat = 0; ana_lat = 3; ndone = 0; nst = 0;
    repeat (16) step(1'b1);
    step(1'b0);
    chk1("s7_fft_start", fft_start, 1'b1);
    for (int k = 1; k <= 30; k++) begin
      step(1'b0);
      if (done) ndone++;
      if (fft_start) nst++;
      if (k == 20) chk1("s7_timeout_pre", timeout, 1'b0);
      if (k == 21) begin
        chk1("s7_timeout", timeout, 1'b1);
        chk1("s7_bank_freed", fft_bank, 1'b1);
        chkn("s7_frame_cnt", 32'(frame_cnt), 0);
      end
    end
    chkn("s7_no_done", ndone, 0);
    chkn("s7_idle_after", nst, 0);
`endif

    // Randomized traffic with stray completion pulses.
    for (int r = 0; r < 6; r++) begin
      reset_dut();
      fft_lat   = $urandom_range(1, 30);
      ana_lat   = $urandom_range(1, 8);
      vp        = $urandom_range(85, 100);
      stray_pct = 5;
      repeat (250) step($urandom_range(0, 99) < vp);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
